// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch sequencer: defaults, state encoding, halt marker.
package fetch_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_TMO   = 255;

  localparam int unsigned STATE_W = 3;

  localparam logic [STATE_W-1:0] S_IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] S_FETCH = 3'd1;
  localparam logic [STATE_W-1:0] S_ISSUE = 3'd2;
  localparam logic [STATE_W-1:0] S_WAIT  = 3'd3;
  localparam logic [STATE_W-1:0] S_HALT  = 3'd4;

  // All ones at any width up to 64; truncated to WIDTH where compared.
  localparam logic [63:0] HALT_WORD = '1;

endpackage : fetch_pkg

// File: rtl/instr_mem.sv
// Program store: one synchronous write port, one asynchronous read port.
module instr_mem
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [WIDTH-1:0] rd_data_c_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_c_o = mem_q[rd_addr_i];

endmodule : instr_mem

// File: rtl/instr_fetch.sv
// Instruction fetch sequencer: steps pc through program memory, handshakes each
// instruction with the processor, and halts on the halt word or a watchdog expiry.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned TMO   = DEF_TMO
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     done,
  input  logic                     ld_en,
  input  logic [$clog2(DEPTH)-1:0] ld_addr,
  input  logic [WIDTH-1:0]         ld_data,
  output logic [WIDTH-1:0]         iin,
  output logic                     run,
  output logic [$clog2(DEPTH)-1:0] pc,
  output logic                     halted,
  output logic                     timeout
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(TMO + 1);

  logic [STATE_W-1:0] state_q, state_d;
  logic [AW-1:0]      pc_q, pc_d;
  logic [WIDTH-1:0]   iin_q, iin_d;
  logic               run_q, run_d;
  logic               halted_q, halted_d;
  logic               timeout_q, timeout_d;
  logic [CW-1:0]      cnt_q, cnt_d;

  logic               wr_en_c;
  logic [WIDTH-1:0]   rd_data_c;
  logic [AW-1:0]      pc_inc_c;
  logic [CW-1:0]      cnt_inc_c;

  // Loading is only allowed while the sequencer is parked.
  assign wr_en_c   = ld_en && ((state_q == S_IDLE) || (state_q == S_HALT));
  assign pc_inc_c  = (pc_q == AW'(DEPTH - 1)) ? '0 : pc_q + AW'(1);
  assign cnt_inc_c = cnt_q + CW'(1);

  instr_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clock       (clock),
    .wr_en_i     (wr_en_c),
    .wr_addr_i   (ld_addr),
    .wr_data_i   (ld_data),
    .rd_addr_i   (pc_q),
    .rd_data_c_o (rd_data_c)
  );

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      iin_q     <= '0;
      run_q     <= 1'b0;
      halted_q  <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      iin_q     <= iin_d;
      run_q     <= run_d;
      halted_q  <= halted_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state and output logic; run is registered out of ISSUE.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    iin_d     = iin_q;
    run_d     = 1'b0;
    halted_d  = halted_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        iin_d = rd_data_c;
        if (rd_data_c == WIDTH'(HALT_WORD)) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        run_d   = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (done) begin
          pc_d    = pc_inc_c;
          cnt_d   = '0;
          state_d = S_FETCH;
        end else begin
          cnt_d = cnt_inc_c;
          if (cnt_inc_c == CW'(TMO)) begin
            state_d   = S_HALT;
            halted_d  = 1'b1;
            timeout_d = 1'b1;
          end
        end
      end
      S_HALT: begin
        if (start) begin
          pc_d      = '0;
          halted_d  = 1'b0;
          timeout_d = 1'b0;
          cnt_d     = '0;
          state_d   = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign iin     = iin_q;
  assign run     = run_q;
  assign pc      = pc_q;
  assign halted  = halted_q;
  assign timeout = timeout_q;

endmodule : instr_fetch

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch; inputs driven and outputs sampled on the falling edge.
module tb_instr_fetch;

  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic        done;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic [15:0] iin;
  logic        run;
  logic [3:0]  pc;
  logic        halted;
  logic        timeout;

  int errors  = 0;
  int checks  = 0;
  int run_cnt = 0;

  instr_fetch dut (
    .clock   (clock),
    .reset   (reset),
    .start   (start),
    .done    (done),
    .ld_en   (ld_en),
    .ld_addr (ld_addr),
    .ld_data (ld_data),
    .iin     (iin),
    .run     (run),
    .pc      (pc),
    .halted  (halted),
    .timeout (timeout)
  );

  always #5 clock = ~clock;

  // Counts every run pulse, including any unexpected ones.
  always @(posedge clock) if (run === 1'b1) run_cnt <= run_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_done();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  // Returns the number of cycles until run is seen high.
  task automatic wait_run(output int n);
    n = 0;
    while (run !== 1'b1 && n < 600) begin
      tick();
      n++;
    end
    if (run !== 1'b1) chk("run_wait_expired", 32'd0, 32'd1);
  endtask

  logic [15:0] prog [5];
  int n;
  int base;

  initial begin
    prog[0] = 16'hA01C; prog[1] = 16'hA40A; prog[2] = 16'h2080;
    prog[3] = 16'h8000; prog[4] = 16'hFFFF;
    reset = 1'b1; start = 1'b0; done = 1'b0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    @(negedge clock);
    do_reset();

    // Reset state
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_iin", 32'(iin), 32'd0);
    chk("rst_run", 32'(run), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);

    // Four-instruction program ending in the halt word
    for (int i = 0; i < 5; i++) load(4'(i), prog[i]);
    base = run_cnt;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      wait_run(n);
      chk($sformatf("prog_lat%0d", i), 32'(n), 32'd2);
      chk($sformatf("prog_iin%0d", i), 32'(iin), 32'(prog[i]));
      chk($sformatf("prog_pc%0d", i), 32'(pc), 32'(i));
      tick(); tick();
      pulse_done();
    end
    n = 0;
    while (halted !== 1'b1 && n < 10) begin tick(); n++; end
    tick(); tick();
    chk("prog_halted", 32'(halted), 32'd1);
    chk("prog_pc_halt", 32'(pc), 32'd4);
    chk("prog_timeout", 32'(timeout), 32'd0);
    chk("prog_runs", 32'(run_cnt - base), 32'd4);

    // done ignored in IDLE and ISSUE
    do_reset();
    base = run_cnt;
    done = 1'b1;
    tick(); tick(); tick();
    done = 1'b0;
    chk("idle_done_pc", 32'(pc), 32'd0);
    chk("idle_done_run", 32'(run_cnt - base), 32'd0);
    pulse_start();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("issue_done_run", 32'(run), 32'd1);
    tick(); tick(); tick();
    chk("issue_done_pc", 32'(pc), 32'd0);
    chk("issue_done_runs", 32'(run_cnt - base), 32'd1);

    // Watchdog expiry, then done winning on the expiry cycle
    do_reset();
    pulse_start();
    wait_run(n);
    base = run_cnt;
    n = 0;
    while (halted !== 1'b1 && n < 400) begin tick(); n++; end
    chk("wd_cycles", 32'(n), 32'd255);
    chk("wd_halted", 32'(halted), 32'd1);
    chk("wd_timeout", 32'(timeout), 32'd1);
    repeat (5) tick();
    chk("wd_no_run", 32'(run_cnt - base), 32'd1);
    chk("wd_timeout_hold", 32'(timeout), 32'd1);
    pulse_start();
    chk("restart_timeout", 32'(timeout), 32'd0);
    chk("restart_halted", 32'(halted), 32'd0);
    wait_run(n);
    repeat (254) tick();
    pulse_done();
    chk("wd_done_wins_halted", 32'(halted), 32'd0);
    chk("wd_done_wins_pc", 32'(pc), 32'd1);

    // pc wrap over all sixteen words
    do_reset();
    for (int i = 0; i < 16; i++) load(4'(i), 16'h8000);
    pulse_start();
    for (int i = 0; i < 17; i++) begin
      wait_run(n);
      chk($sformatf("wrap_iin%0d", i), 32'(iin), 32'h8000);
      chk($sformatf("wrap_pc%0d", i), 32'(pc), 32'(i % 16));
      pulse_done();
    end

    // Reset mid-operation keeps memory
    do_reset();
    load(4'd0, 16'hA01C);
    load(4'd1, 16'hA40A);
    pulse_start();
    wait_run(n);
    pulse_done();
    wait_run(n);
    chk("mid_pc1", 32'(pc), 32'd1);
    chk("mid_iin1", 32'(iin), 32'hA40A);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_rst_run", 32'(run), 32'd0);
    chk("mid_rst_pc", 32'(pc), 32'd0);
    chk("mid_rst_iin", 32'(iin), 32'd0);
    tick(); tick();
    chk("mid_idle_run", 32'(run), 32'd0);
    pulse_start();
    wait_run(n);
    chk("mid_restart_lat", 32'(n), 32'd2);
    chk("mid_restart_iin", 32'(iin), 32'hA01C);

    // Load and start together; load outside IDLE/HALT ignored
    do_reset();
    ld_en = 1'b1; ld_addr = 4'd0; ld_data = 16'h2080; start = 1'b1;
    tick();
    ld_en = 1'b0; start = 1'b0;
    wait_run(n);
    chk("ldst_lat", 32'(n), 32'd2);
    chk("ldst_iin", 32'(iin), 32'h2080);
    load(4'd1, 16'h1234);
    pulse_done();
    wait_run(n);
    chk("ld_wait_pc", 32'(pc), 32'd1);
    chk("ld_wait_ignored", 32'(iin), 32'hA40A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got expired expected finished");
    $fatal(1, "time limit");
  end

endmodule : tb_instr_fetch

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter WIDTH, default 16: instruction word width.
REQ-002 SHALL have parameter DEPTH, default 16: program memory words; the address width is log2(DEPTH), which is 4 at the default.
REQ-003 SHALL have parameter TMO, default 255: the maximum number of WAIT cycles before the watchdog fires.
REQ-004 SHALL have ports, one per line (name  direction  width  meaning):
  clock  in  1  single clock; all state updates on its rising edge
  reset  in  1  synchronous, active-high reset
  start  in  1  begin or restart program execution
  done  in  1  processor has finished the current instruction
  ld_en  in  1  program-memory write enable
  ld_addr  in  log2(DEPTH)  program-memory write address
  ld_data  in  WIDTH  program-memory write data
  iin  out  WIDTH  instruction word driven to the processor's instruction input
  run  out  1  one-cycle pulse marking a new instruction on iin
  pc  out  log2(DEPTH)  address of the current instruction
  halted  out  1  halt word reached, or watchdog fired
  timeout  out  1  watchdog fired

Function
REQ-005 SHALL implement FSM states IDLE, FETCH, ISSUE, WAIT and HALT, with iin, run, pc, halted and timeout all registered outputs.
REQ-006 IDLE: with start=1, SHALL go to FETCH at the next edge; otherwise it SHALL remain in IDLE.
REQ-007 SHALL write mem[ld_addr]<=ld_data only when ld_en=1 in IDLE or HALT; ld_en in any other state SHALL be ignored.
REQ-008 FETCH: SHALL register iin<=mem[pc]; if that word equals HALT_WORD (all ones), it SHALL go to HALT and not issue it, otherwise to ISSUE.
REQ-009 ISSUE: SHALL assert run=1 for exactly this one cycle, then go to WAIT.
REQ-010 WAIT: SHALL increment a watchdog counter every cycle; on done=1 it SHALL set pc<=pc+1, clear the counter and go to FETCH.
REQ-011 SHALL wrap pc from DEPTH-1 to 0 on increment; no flag is raised on wrap.
REQ-012 SHALL sample done only in WAIT; done in every other state SHALL be ignored.
REQ-013 Watchdog: when the counter reaches TMO in WAIT with done=0, SHALL go to HALT with timeout=1; if done=1 in the same cycle, done SHALL win.
REQ-014 HALT: halted=1; timeout SHALL hold its value; start=1 SHALL clear pc, halted, timeout and the counter, then go to FETCH.
REQ-015 SHALL hold iin stable from ISSUE until the next FETCH edge.
REQ-016 Latency: start sampled to run pulse SHALL be 2 cycles; done sampled to next run pulse SHALL be 2 cycles.
REQ-017 Simultaneous ld_en and start in IDLE: the write SHALL complete before FETCH reads, so FETCH sees the new word when ld_addr==pc.

Reset
REQ-018 reset=1 at an edge SHALL force state=IDLE, pc=0, iin=0, run=0, halted=0, timeout=0 and counter=0, taking priority over all other inputs.
REQ-019 reset mid-operation (ISSUE or WAIT) SHALL drop run at that same edge.
REQ-020 Program memory contents SHALL NOT be cleared by reset.

Structure
REQ-021 Package fetch_pkg SHALL hold the state encoding, HALT_WORD and the default WIDTH, DEPTH and TMO values.
REQ-022 Program storage SHALL be a sub-module instr_mem: DEPTH x WIDTH, one synchronous write port, one asynchronous read port indexed by pc.
REQ-023 The FSM, pc and watchdog SHALL reside in instr_fetch; total RTL 120-400 lines.

Verification
REQ-024 Bench SHALL load 0xA01C, 0xA40A, 0x2080, 0x8000, 0xFFFF at addresses 0..4, pulse start, and return done 3 cycles after each run -> iin shows the 4 words in order, 4 run pulses, halted=1 with pc=4, timeout=0.
REQ-025 Bench SHALL load 0xA01C at address 0, pulse start, never assert done -> after 255 WAIT cycles halted=1, timeout=1, run never pulses again.
REQ-026 Bench SHALL fill all 16 words with 0x8000 and answer every run with done -> pc steps 15 to 0 and a 17th run pulse shows iin=0x8000.
REQ-027 Bench SHALL assert reset=1 during WAIT after the second instruction -> next edge: pc=0, run=0, iin=0, IDLE; start then re-fetches mem[0]=0xA01C unchanged.
REQ-028 Bench SHALL assert done during ISSUE and during IDLE -> ignored: no pc change and no extra run pulse.
REQ-029 Bench SHALL drive ld_en=1, ld_addr=0, ld_data=0x2080 and start=1 in the same IDLE cycle -> the first run pulse shows iin=0x2080.
